// File: rtl/bram_arb_pkg.sv
// Shared types and sizing helpers for the dual-port BRAM arbiter.
// Optional feature macro: BRAM_ARB_PERF_EN (performance counters).
package bram_arb_pkg;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   localparam int PERF_W = 32;

   // Requester index width; a single requester still needs one bit.
   function automatic int idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit of i_mask at or after i_start, cyclic.
module rr_pick #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   i_mask,
   input  logic [IDW-1:0] i_start,
   output logic           o_hit,
   output logic [IDW-1:0] o_idx
);

   // Walk offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      int j;
      j     = 0;
      o_hit = 1'b0;
      o_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(i_start) + k;
         if (j >= N) j = j - N;
         if (i_mask[j]) begin
            o_hit = 1'b1;
            o_idx = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing both ports of one dual-port BRAM among NREQ requesters.
// Define BRAM_ARB_PERF_EN to add saturating grant/stall performance counters.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DATA = 72,
   parameter int ADDR = 10
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NREQ-1:0]      i_req_valid,
   output logic [NREQ-1:0]      o_req_ready,
   input  logic [NREQ-1:0]      i_req_wr,
   input  logic [NREQ*ADDR-1:0] i_req_addr,
   input  logic [NREQ*DATA-1:0] i_req_din,
   output logic [NREQ-1:0]      o_rsp_valid,
   output logic [NREQ*DATA-1:0] o_rsp_data,
   output logic                 o_a_wr,
   output logic [ADDR-1:0]      o_a_addr,
   output logic [DATA-1:0]      o_a_din,
   input  logic [DATA-1:0]      i_a_dout,
   output logic                 o_b_wr,
   output logic [ADDR-1:0]      o_b_addr,
   output logic [DATA-1:0]      o_b_din,
   input  logic [DATA-1:0]      i_b_dout
`ifdef BRAM_ARB_PERF_EN
   ,
   output logic [NREQ*PERF_W-1:0] o_perf_grants,
   output logic [PERF_W-1:0]      o_perf_stalls
`endif
);

   localparam int IDW = idw(NREQ);

   logic [IDW-1:0]       r_rrPtr;
   logic [1:0]           r_tagVld;
   logic [IDW-1:0]       r_tagId [2];
   logic [NREQ*DATA-1:0] r_rspHold;

   logic                 w_hitA, w_hitB, w_conflict, w_grantA, w_grantB;
   logic [IDW-1:0]       w_idxA, w_idxB, w_startB;
   logic [NREQ-1:0]      w_maskB;
   logic                 w_wrA, w_wrB;
   logic [ADDR-1:0]      w_addrA, w_addrB;
   logic [DATA-1:0]      w_dinA, w_dinB;
   logic [NREQ-1:0]      w_rspValid;
   logic [NREQ*DATA-1:0] w_rspData;

   function automatic logic [IDW-1:0] wrapInc(input logic [IDW-1:0] v);
      return (int'(v) >= NREQ - 1) ? '0 : v + IDW'(1);
   endfunction

   assign w_startB = wrapInc(w_idxA);
   assign w_maskB  = i_req_valid & ~(NREQ'(1) << w_idxA);

   rr_pick #(.N(NREQ), .IDW(IDW)) u_pickA (
      .i_mask  (i_req_valid),
      .i_start (r_rrPtr),
      .o_hit   (w_hitA),
      .o_idx   (w_idxA)
   );

   rr_pick #(.N(NREQ), .IDW(IDW)) u_pickB (
      .i_mask  (w_maskB),
      .i_start (w_startB),
      .o_hit   (w_hitB),
      .o_idx   (w_idxB)
   );

   assign w_wrA   = i_req_wr[w_idxA];
   assign w_wrB   = i_req_wr[w_idxB];
   assign w_addrA = i_req_addr[int'(w_idxA)*ADDR +: ADDR];
   assign w_addrB = i_req_addr[int'(w_idxB)*ADDR +: ADDR];
   assign w_dinA  = i_req_din[int'(w_idxA)*DATA +: DATA];
   assign w_dinB  = i_req_din[int'(w_idxB)*DATA +: DATA];

   // Only a read/read pair may share an address across the two ports.
   assign w_conflict = (w_addrA == w_addrB) && (w_wrA || w_wrB);
   assign w_grantA   = i_rst_n && w_hitA;
   assign w_grantB   = w_grantA && w_hitB && !w_conflict;

   always_comb begin
      o_req_ready = '0;
      o_a_wr      = 1'b0;
      o_a_addr    = '0;
      o_a_din     = '0;
      o_b_wr      = 1'b0;
      o_b_addr    = '0;
      o_b_din     = '0;
      if (w_grantA) begin
         o_req_ready[w_idxA] = 1'b1;
         o_a_wr              = w_wrA;
         o_a_addr            = w_addrA;
         o_a_din             = w_dinA;
      end
      if (w_grantB) begin
         o_req_ready[w_idxB] = 1'b1;
         o_b_wr              = w_wrB;
         o_b_addr            = w_addrB;
         o_b_din             = w_dinB;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rrPtr         <= '0;
         r_tagVld        <= '0;
         r_tagId[PORT_A] <= '0;
         r_tagId[PORT_B] <= '0;
      end else begin
         if (w_grantB)      r_rrPtr <= wrapInc(w_idxB);
         else if (w_grantA) r_rrPtr <= wrapInc(w_idxA);
         r_tagVld[PORT_A] <= w_grantA && !w_wrA;
         r_tagVld[PORT_B] <= w_grantB && !w_wrB;
         r_tagId[PORT_A]  <= w_idxA;
         r_tagId[PORT_B]  <= w_idxB;
      end
   end

   // BRAM dout is valid the cycle after the grant; steer it by the port tag.
   always_comb begin
      w_rspValid = '0;
      w_rspData  = r_rspHold;
      if (r_tagVld[PORT_A]) begin
         w_rspValid[r_tagId[PORT_A]]                  = 1'b1;
         w_rspData[int'(r_tagId[PORT_A])*DATA +: DATA] = i_a_dout;
      end
      if (r_tagVld[PORT_B]) begin
         w_rspValid[r_tagId[PORT_B]]                  = 1'b1;
         w_rspData[int'(r_tagId[PORT_B])*DATA +: DATA] = i_b_dout;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_rspHold <= '0;
      else          r_rspHold <= w_rspData;
   end

   assign o_rsp_valid = w_rspValid;
   assign o_rsp_data  = w_rspData;

`ifdef BRAM_ARB_PERF_EN
   logic [PERF_W-1:0] r_perfGrants [NREQ];
   logic [PERF_W-1:0] r_perfStalls;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NREQ; i++) r_perfGrants[i] <= '0;
         r_perfStalls <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (o_req_ready[i] && i_req_valid[i] && (r_perfGrants[i] != '1))
               r_perfGrants[i] <= r_perfGrants[i] + PERF_W'(1);
         end
         if (w_grantA && w_hitB && w_conflict && (r_perfStalls != '1))
            r_perfStalls <= r_perfStalls + PERF_W'(1);
      end
   end

   always_comb begin
      o_perf_grants = '0;
      for (int i = 0; i < NREQ; i++) o_perf_grants[i*PERF_W +: PERF_W] = r_perfGrants[i];
   end

   assign o_perf_stalls = r_perfStalls;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed table, hand sequences and randomized traffic
// compared against a queue-based round-robin reference model with its own memory.
module tb_bram_port_arbiter;

   localparam int N = 4;
   localparam int D = 72;
   localparam int A = 10;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N-1:0]   reqValid, reqReady, reqWr, rspValid;
   logic [N*A-1:0] reqAddr;
   logic [N*D-1:0] reqDin, rspData;
   logic           aWr, bWr;
   logic [A-1:0]   aAddr, bAddr;
   logic [D-1:0]   aDin, bDin, aDout, bDout;
`ifdef BRAM_ARB_PERF_EN
   logic [N*32-1:0] perfGrants;
   logic [31:0]     perfStalls;
`endif

   logic [D-1:0] bramMem [1024];
   logic [D-1:0] refMem  [1024];
   logic         loadMem;

   int total = 0;
   int bad   = 0;

   bram_port_arbiter #(.NREQ(N), .DATA(D), .ADDR(A)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (reqValid),
      .o_req_ready (reqReady),
      .i_req_wr    (reqWr),
      .i_req_addr  (reqAddr),
      .i_req_din   (reqDin),
      .o_rsp_valid (rspValid),
      .o_rsp_data  (rspData),
      .o_a_wr      (aWr),
      .o_a_addr    (aAddr),
      .o_a_din     (aDin),
      .i_a_dout    (aDout),
      .o_b_wr      (bWr),
      .o_b_addr    (bAddr),
      .o_b_din     (bDin),
      .i_b_dout    (bDout)
`ifdef BRAM_ARB_PERF_EN
      ,
      .o_perf_grants (perfGrants),
      .o_perf_stalls (perfStalls)
`endif
   );

   // Behavioural dual-port BRAM with registered, write-through read data.
   always @(posedge clk) begin
      if (loadMem) begin
         for (int k = 0; k < 1024; k++) bramMem[k] <= refMem[k];
      end else begin
         if (aWr) bramMem[aAddr] <= aDin;
         if (bWr) bramMem[bAddr] <= bDin;
      end
      aDout <= aWr ? aDin : bramMem[aAddr];
      bDout <= bWr ? bDin : bramMem[bAddr];
   end

   typedef struct packed {
      logic [3:0]  valid;
      logic [3:0]  wr;
      logic [39:0] addrs;
      logic [3:0]  expReady;
      logic [9:0]  expA;
      logic [9:0]  expB;
      logic        expAwr;
      logic        expBwr;
      logic [3:0]  expRsp;
   } vec_t;

   vec_t vecs [8];

   function automatic logic [39:0] addrs4(input logic [9:0] a0, input logic [9:0] a1,
                                          input logic [9:0] a2, input logic [9:0] a3);
      return {a3, a2, a1, a0};
   endfunction

   function automatic vec_t mkVec(input logic [3:0] v, input logic [3:0] w, input logic [39:0] ad,
                                  input logic [3:0] er, input logic [9:0] ea, input logic [9:0] eb,
                                  input logic eaw, input logic ebw, input logic [3:0] ers);
      vec_t t;
      t.valid = v; t.wr = w; t.addrs = ad; t.expReady = er; t.expA = ea; t.expB = eb;
      t.expAwr = eaw; t.expBwr = ebw; t.expRsp = ers;
      return t;
   endfunction

   task automatic applyStimulus(input logic [3:0] v, input logic [3:0] w,
                                input logic [39:0] ad, input logic [287:0] dn);
      reqValid = v;
      reqWr    = w;
      reqAddr  = ad;
      reqDin   = dn;
   endtask

   task automatic checkOutput(input string name, input logic [287:0] act, input logic [287:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [3:0]  pend;
   logic [9:0]  mAddr [4];
   logic        mWr   [4];
   logic [71:0] mDin  [4];
   logic [71:0] mHold [4];
   logic [3:0]  mRsp;
   int          mPtr;
   int          order [$];
   int          ga, gb, g;
   logic [3:0]  wrF, expReady;
   logic [39:0] addrF;
   logic [287:0] dinF;
   logic [82:0] expPortA, expPortB;

   initial begin
      for (int k = 0; k < 1024; k++) refMem[k] = {8'($urandom), $urandom, $urandom};
      refMem[5] = 72'hAB;

      // Reset with every requester asking to write.
      rst_n   = 1'b0;
      loadMem = 1'b1;
      applyStimulus(4'hF, 4'hF, addrs4(10'd1, 10'd2, 10'd3, 10'd4), '1);
      #1;
      checkOutput("reset ready", reqReady, 4'b0000);
      checkOutput("reset wr", {aWr, bWr}, 2'b00);
      checkOutput("reset rsp_valid", rspValid, 4'b0000);
      checkOutput("reset rsp_data", rspData, '0);
      @(negedge clk);
      loadMem = 1'b0;
      rst_n   = 1'b1;

      // Single read by requester 2.
      applyStimulus(4'b0100, 4'b0000, addrs4(10'd0, 10'd0, 10'h005, 10'd0), '0);
      #1;
      checkOutput("single ready", reqReady, 4'b0100);
      checkOutput("single a_addr", aAddr, 10'h005);
      checkOutput("single wr", {aWr, bWr}, 2'b00);
      @(negedge clk);
      applyStimulus(4'b0000, 4'b0000, '0, '0);
      #1;
      checkOutput("single rsp_valid", rspValid, 4'b0100);
      checkOutput("single rsp_data", rspData[2*D +: D], 72'hAB);
      @(negedge clk);

      // Write/read hazard on address 7: only the writer wins, reader follows.
      applyStimulus(4'b0011, 4'b0001, addrs4(10'd7, 10'd7, 10'd0, 10'd0), 288'h77);
      #1;
      checkOutput("hazard ready", reqReady, 4'b0001);
      checkOutput("hazard a", {aWr, aAddr}, {1'b1, 10'd7});
      checkOutput("hazard b_wr", bWr, 1'b0);
      @(negedge clk);
      applyStimulus(4'b0010, 4'b0000, addrs4(10'd0, 10'd7, 10'd0, 10'd0), '0);
      #1;
      checkOutput("hazard ready2", reqReady, 4'b0010);
      checkOutput("hazard no wr rsp", rspValid, 4'b0000);
      @(negedge clk);
      applyStimulus(4'b0000, 4'b0000, '0, '0);
      #1;
      checkOutput("hazard rsp_valid", rspValid, 4'b0010);
      checkOutput("hazard rsp_data", rspData[1*D +: D], 72'h77);
      @(negedge clk);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      vecs[0] = mkVec(4'hF, 4'h0, addrs4(10'd10, 10'd11, 10'd12, 10'd13), 4'b0011, 10'd10, 10'd11, 1'b0, 1'b0, 4'b0000);
      vecs[1] = mkVec(4'hF, 4'h0, addrs4(10'd10, 10'd11, 10'd12, 10'd13), 4'b1100, 10'd12, 10'd13, 1'b0, 1'b0, 4'b0011);
      vecs[2] = mkVec(4'hF, 4'h0, addrs4(10'd10, 10'd11, 10'd12, 10'd13), 4'b0011, 10'd10, 10'd11, 1'b0, 1'b0, 4'b1100);
      vecs[3] = mkVec(4'b0001, 4'h0, addrs4(10'd20, 10'd0, 10'd0, 10'd0), 4'b0001, 10'd20, 10'd0, 1'b0, 1'b0, 4'b0011);
      vecs[4] = mkVec(4'b0101, 4'b0001, addrs4(10'd30, 10'd0, 10'd30, 10'd0), 4'b0100, 10'd30, 10'd0, 1'b0, 1'b0, 4'b0001);
      vecs[5] = mkVec(4'b1010, 4'h0, addrs4(10'd0, 10'h3FF, 10'd0, 10'h3FF), 4'b1010, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 4'b0100);
      vecs[6] = mkVec(4'b0000, 4'h0, addrs4(10'd0, 10'd0, 10'd0, 10'd0), 4'b0000, 10'd0, 10'd0, 1'b0, 1'b0, 4'b1010);
      vecs[7] = mkVec(4'b1001, 4'b1001, addrs4(10'd40, 10'd0, 10'd0, 10'd41), 4'b1001, 10'd41, 10'd40, 1'b1, 1'b1, 4'b0000);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].wr, vecs[i].addrs, '0);
         #1;
         checkOutput($sformatf("vec%0d ready", i), reqReady, vecs[i].expReady);
         checkOutput($sformatf("vec%0d ports", i), {aWr, aAddr, bWr, bAddr},
                     {vecs[i].expAwr, vecs[i].expA, vecs[i].expBwr, vecs[i].expB});
         checkOutput($sformatf("vec%0d rsp_valid", i), rspValid, vecs[i].expRsp);
         for (int j = 0; j < N; j++) begin
            if (i > 0 && vecs[i].expRsp[j])
               checkOutput($sformatf("vec%0d rsp_data%0d", i, j), rspData[j*D +: D],
                           refMem[vecs[i-1].addrs[j*10 +: 10]]);
         end
         @(negedge clk);
      end

      // Reset one cycle after a read grant drops the response and rewinds the pointer.
      applyStimulus(4'b0010, 4'b0000, addrs4(10'd0, 10'd50, 10'd0, 10'd0), '0);
      #1;
      checkOutput("drop ready", reqReady, 4'b0010);
      @(negedge clk);
      rst_n = 1'b0;
      applyStimulus(4'b0000, 4'b0000, '0, '0);
      #1;
      checkOutput("drop rsp in reset", rspValid, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("drop rsp after reset", rspValid, 4'b0000);
      applyStimulus(4'b0110, 4'b0000, addrs4(10'd0, 10'd60, 10'd61, 10'd0), '0);
      #1;
      checkOutput("ptr rewind ready", reqReady, 4'b0110);
      checkOutput("ptr rewind a_addr", aAddr, 10'd60);
      checkOutput("ptr rewind b_addr", bAddr, 10'd61);
      @(negedge clk);

      // Randomized traffic against the reference model.
      rst_n   = 1'b0;
      loadMem = 1'b1;
      applyStimulus(4'b0000, 4'b0000, '0, '0);
      @(negedge clk);
      loadMem = 1'b0;
      rst_n   = 1'b1;
      pend = '0;
      mRsp = '0;
      mPtr = 0;
      for (int i = 0; i < N; i++) begin
         mHold[i] = '0; mAddr[i] = '0; mWr[i] = 1'b0; mDin[i] = '0;
      end

      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 9) < 6) begin
               pend[i]  = 1'b1;
               mWr[i]   = 1'($urandom_range(0, 1));
               mAddr[i] = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 7));
               mDin[i]  = {8'($urandom), $urandom, $urandom};
            end
         end
         for (int i = 0; i < N; i++) begin
            wrF[i]           = mWr[i];
            addrF[i*A +: A]  = mAddr[i];
            dinF[i*D +: D]   = mDin[i];
         end
         applyStimulus(pend, wrF, addrF, dinF);
         #1;

         order.delete();
         for (int k = 0; k < N; k++) if (pend[(mPtr + k) % N]) order.push_back((mPtr + k) % N);
         ga = -1;
         gb = -1;
         if (order.size() > 0) ga = order[0];
         if (order.size() > 1) begin
            gb = order[1];
            if (mAddr[gb] == mAddr[ga] && (mWr[ga] || mWr[gb])) gb = -1;
         end
         expReady = '0;
         expPortA = '0;
         expPortB = '0;
         if (ga >= 0) begin
            expReady[ga] = 1'b1;
            expPortA     = {mWr[ga], mAddr[ga], mDin[ga]};
         end
         if (gb >= 0) begin
            expReady[gb] = 1'b1;
            expPortB     = {mWr[gb], mAddr[gb], mDin[gb]};
         end

         checkOutput("rand ready", reqReady, expReady);
         checkOutput("rand port a", {aWr, aAddr, aDin}, expPortA);
         checkOutput("rand port b", {bWr, bAddr, bDin}, expPortB);
         checkOutput("rand rsp_valid", rspValid, mRsp);
         checkOutput("rand rsp_data", rspData, {mHold[3], mHold[2], mHold[1], mHold[0]});

         mRsp = '0;
         for (int p = 0; p < 2; p++) begin
            g = (p == 0) ? ga : gb;
            if (g >= 0) begin
               if (mWr[g]) refMem[mAddr[g]] = mDin[g];
               else begin
                  mRsp[g]  = 1'b1;
                  mHold[g] = refMem[mAddr[g]];
               end
               pend[g] = 1'b0;
            end
         end
         if (gb >= 0)      mPtr = (gb + 1) % N;
         else if (ga >= 0) mPtr = (ga + 1) % N;
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
